// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: size encodings, FSM states,
// byte-enable type and the captured request payload.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef logic [1:0] size_t;

  localparam size_t SIZE_B = 2'b00;
  localparam size_t SIZE_H = 2'b01;
  localparam size_t SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic [3:0] byte_en_t;

  // Request fields as presented by the core
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    size_t             size;
    logic              uns;
  } dmem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Ports: size/lane/is_unsigned select the access; wdata is right-aligned
// store data; rword is the addressed RAM word. Outputs byte enables, the
// lane-replicated write word and the extended load result.
module mem_lane_align
  import dmem_pkg::*;
(
  input  size_t             size,
  input  logic [1:0]        lane,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output byte_en_t          be,
  output logic [DATA_W-1:0] wword,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
    be    = '0;
    wword = '0;
    rdata = '0;
    case (size)
      SIZE_B: begin
        be    = byte_en_t'(4'b0001 << lane);
        wword = {4{wdata[7:0]}};
        rdata = is_unsigned ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SIZE_H: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rdata = is_unsigned ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      SIZE_W: begin
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core load/store port: valid/ready request and
// response, word RAM with byte/half/word access, programmable wait states.
// Ports: clk/reset (sync, active-high); req_* request channel from the core;
// rsp_* response channel back to the core.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter int unsigned       LATENCY     = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  size_t             req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam int unsigned SPAN_BYTES = DEPTH_WORDS * 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_e            state_q, next_state;
  dmem_req_t         req_live, req_q, src;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, commit, err;
  logic              req_ready_d, rsp_valid_d;
  logic [ADDR_W-1:0] off;
  logic [AW-1:0]     widx;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] rword, wword, load_data;
  byte_en_t          be;

  assign req_live = {req_we, req_addr, req_wdata, req_size, req_unsigned};
  assign accept   = (state_q == IDLE) && req_ready && req_valid;
  // Commit happens on the edge that enters RESP
  assign commit   = (next_state == RESP) && (state_q != RESP);
  // With zero latency the commit edge is the accept edge, so use live inputs
  assign src      = (state_q == IDLE) ? req_live : req_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE: if (accept) next_state = (LATENCY > 0) ? WAIT : RESP;
      WAIT: if (cnt_q == '0) next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output next values; ready reopens one cycle after returning to IDLE
  always_comb begin
    req_ready_d = (state_q == IDLE) && (next_state == IDLE);
    rsp_valid_d = (next_state == RESP);
  end

  // Error check and addressing
  always_comb begin
    off  = src.addr - BASE_ADDR;
    widx = off[AW+1:2];
    err  = (off >= ADDR_W'(SPAN_BYTES))
        || (src.size == 2'b11)
        || ((src.size == SIZE_H) && src.addr[0])
        || ((src.size == SIZE_W) && (src.addr[1:0] != 2'b00));
  end

  assign rword = mem[widx];

  mem_lane_align u_align (
    .size        (src.size),
    .lane        (src.addr[1:0]),
    .is_unsigned (src.uns),
    .wdata       (src.wdata),
    .rword       (rword),
    .be          (be),
    .wword       (wword),
    .rdata       (load_data)
  );

  // Registered outputs and wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      if (accept) cnt_q <= CNT_INIT;
      else if ((state_q == WAIT) && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
      if (commit) begin
        rsp_err   <= err;
        rsp_rdata <= (err || src.we) ? '0 : load_data;
      end
    end
  end

  // Request capture
  always_ff @(posedge clk) begin
    if (accept) req_q <= req_live;
  end

  // RAM write; a reset on the commit edge drops the store
  always_ff @(posedge clk) begin
    if (!reset && commit && !err && src.we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2) plus a zero-latency instance.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        z_valid, z_ready, z_rsp_valid, z_err;
  logic [31:0] z_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .BASE_ADDR(32'h0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_valid), .req_ready(z_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(z_rdata), .rsp_err(z_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
  endtask

  // One full transaction on the LATENCY=2 instance with rsp_ready high
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int n;
    @(negedge clk);
    set_req(we, addr, wdata, size, uns);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, "/lat"}, 32'(n), 32'd3);
    check({tag, "/rdata"}, rsp_rdata, exp_rdata);
    check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  // Accept on the zero-latency instance; response must be up one cycle later
  task automatic zxact(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata);
    int n;
    @(negedge clk);
    set_req(we, addr, wdata, SIZE_W, 1'b0);
    z_valid = 1'b1;
    n = 0;
    while (!z_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "/ready"}, 32'(z_ready), 32'd1);
    @(negedge clk);
    z_valid = 1'b0;
    check({tag, "/valid"}, 32'(z_rsp_valid), 32'd1);
    check({tag, "/rdata"}, z_rdata, exp_rdata);
    check({tag, "/err"}, 32'(z_err), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0; z_valid = 1'b0; rsp_ready = 1'b1;
    set_req(1'b0, 32'h0, 32'h0, SIZE_W, 1'b0);
    repeat (2) @(negedge clk);
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst/rsp_rdata", rsp_rdata, 32'd0);
    check("rst/rsp_err",   32'(rsp_err), 32'd0);
    check("rst/z_ready",   32'(z_ready), 32'd0);
    reset = 1'b0;

    // Word store/load and byte lane steering
    xact("st_w10",  1'b1, 32'h10, 32'hDEADBEEF, SIZE_W, 1'b0, 32'h0, 1'b0);
    xact("ld_w10",  1'b0, 32'h10, 32'h0,        SIZE_W, 1'b0, 32'hDEADBEEF, 1'b0);
    xact("st_b13",  1'b1, 32'h13, 32'h00000080, SIZE_B, 1'b0, 32'h0, 1'b0);
    xact("ld_bs13", 1'b0, 32'h13, 32'h0,        SIZE_B, 1'b0, 32'hFFFFFF80, 1'b0);
    xact("ld_bu13", 1'b0, 32'h13, 32'h0,        SIZE_B, 1'b1, 32'h00000080, 1'b0);
    xact("ld_w10b", 1'b0, 32'h10, 32'h0,        SIZE_W, 1'b1, 32'h80ADBEEF, 1'b0);
    xact("ld_hs12", 1'b0, 32'h12, 32'h0,        SIZE_H, 1'b0, 32'hFFFF80AD, 1'b0);
    xact("ld_hu10", 1'b0, 32'h10, 32'h0,        SIZE_H, 1'b1, 32'h0000BEEF, 1'b0);
    xact("ld_bs11", 1'b0, 32'h11, 32'h0,        SIZE_B, 1'b0, 32'hFFFFFFBE, 1'b0);

    // Misaligned half store leaves RAM untouched
    xact("st_w20",  1'b1, 32'h20, 32'h11223344, SIZE_W, 1'b0, 32'h0, 1'b0);
    xact("st_h21",  1'b1, 32'h21, 32'h00001234, SIZE_H, 1'b0, 32'h0, 1'b1);
    xact("ld_w20",  1'b0, 32'h20, 32'h0,        SIZE_W, 1'b0, 32'h11223344, 1'b0);
    xact("st_h22",  1'b1, 32'h22, 32'hFFFF5AA5, SIZE_H, 1'b0, 32'h0, 1'b0);
    xact("ld_w20b", 1'b0, 32'h20, 32'h0,        SIZE_W, 1'b0, 32'h5AA53344, 1'b0);
    xact("ld_w12",  1'b0, 32'h12, 32'h0,        SIZE_W, 1'b0, 32'h0, 1'b1);

    // Range boundary, aliasing and illegal size
    xact("st_w3fc", 1'b1, 32'h3FC, 32'h0BADCAFE, SIZE_W, 1'b0, 32'h0, 1'b0);
    xact("ld_w3fc", 1'b0, 32'h3FC, 32'h0,        SIZE_W, 1'b0, 32'h0BADCAFE, 1'b0);
    xact("st_w0",   1'b1, 32'h0,   32'h13579BDF, SIZE_W, 1'b0, 32'h0, 1'b0);
    xact("st_w400", 1'b1, 32'h400, 32'hFFFFFFFF, SIZE_W, 1'b0, 32'h0, 1'b1);
    xact("ld_w400", 1'b0, 32'h400, 32'h0,        SIZE_W, 1'b0, 32'h0, 1'b1);
    xact("ld_w0",   1'b0, 32'h0,   32'h0,        SIZE_W, 1'b0, 32'h13579BDF, 1'b0);
    xact("ld_sz3",  1'b0, 32'h10,  32'h0,        2'b11,  1'b0, 32'h0, 1'b1);

    // Response backpressure; a request presented meanwhile is ignored
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1'b0, 32'h10, 32'h0, SIZE_W, 1'b0);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("bp/ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp/rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp/rsp_rdata", rsp_rdata, 32'h80ADBEEF);
      check("bp/rsp_err",   32'(rsp_err), 32'd0);
      check("bp/req_ready", 32'(req_ready), 32'd0);
      set_req(1'b1, 32'h10, 32'h0, SIZE_W, 1'b0);
      req_valid = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp/released", 32'(rsp_valid), 32'd0);
    xact("bp_ld10", 1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, 32'h80ADBEEF, 1'b0);

    // Reset one cycle after accepting a store drops the store
    xact("st_w30", 1'b1, 32'h30, 32'h55667788, SIZE_W, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    set_req(1'b1, 32'h30, 32'hCAFEF00D, SIZE_W, 1'b0);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("rw/ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rw/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rw/req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("rw/ready_after", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("rw/no_rsp", 32'(rsp_valid), 32'd0);
    xact("rw_ld30", 1'b0, 32'h30, 32'h0, SIZE_W, 1'b0, 32'h55667788, 1'b0);

    // Zero-latency instance
    zxact("z_st40", 1'b1, 32'h40, 32'h0F1E2D3C, 32'h0);
    zxact("z_ld40", 1'b0, 32'h40, 32'h0,        32'h0F1E2D3C);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
